dab_gate_deadtime: RTL and testbench
====================================

Name: dab_gate_deadtime

Overview:
- Downstream stage of the DAB voltage-pattern generator. Consumes the three-level bridge commands V1 (primary) and V2 (secondary).
- Produces the eight gate signals: Sp[3:0] for the primary H-bridge and Ss[3:0] for the secondary H-bridge.
- Inserts a programmable dead time on every leg commutation.
- Provides a global gate enable and a sticky fault shutdown on illegal voltage codes.
- Sits between the voltaje pattern block and the FPGA gate-driver pins.

Parameters:
DT_WIDTH, 8, width of dead-time count input and per-leg counters
DT_MIN, 2, minimum dead time in CE cycles; smaller requests are clamped up to this

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is synchronous and active-low
CE  in  1  clock enable; all state, counters and input registers advance only when CE=1
en  in  1  gate enable; 0 forces all gates off
dt_cuentas  in  DT_WIDTH  requested dead time, in CE cycles
V1  in  2 signed  primary command: +1, 0, -1
V2  in  2 signed  secondary command: +1, 0, -1
Sp  out  4  primary gates: [0]=S1 leg A top, [1]=S2 leg A bottom, [2]=S3 leg B top, [3]=S4 leg B bottom
Ss  out  4  secondary gates, same bit order
fault  out  1  sticky; 1 after an illegal code (2'b10) on V1 or V2

Behaviour:
- Reset (rst=0 at a clk edge, regardless of CE):
  - Sp=Ss=0, fault=0.
  - V1_r=V2_r=0.
  - All four legs enter OFF; counters cleared.
- Input stage: V1/V2 are registered into V1_r/V2_r on each CE edge (1 cycle latency).
- Desired leg state is decoded from the registered value:
  - +1: leg A HIGH, leg B LOW.
  - -1: leg A LOW, leg B HIGH.
  - 0: both legs LOW (S2,S4 on).
- Effective dead time: dt_eff = max(dt_cuentas, DT_MIN). It is sampled when a leg enters a DT state; a later dt_cuentas change does not affect a DT already in progress.
- Per-leg FSM (4 identical instances). States and outputs:
  - OFF: top=0, bottom=0. If en=1 and fault=0, go to DT_TO_HIGH or DT_TO_LOW per the desired state, with counter=dt_eff.
  - LOW_ON: bottom=1. If desired=HIGH, go to DT_TO_HIGH and load counter.
  - DT_TO_HIGH: both 0. Counter decrements each CE cycle; at counter==1, go to HIGH_ON. If desired returns to LOW before expiry, go to LOW_ON next edge (bottom re-asserts; top never pulsed).
  - HIGH_ON: top=1. If desired=LOW, go to DT_TO_LOW.
  - DT_TO_LOW: symmetric to DT_TO_HIGH.
- Gate outputs are registered from the FSM state.
- Timing: V change sampled at edge k (V_r updated) → outgoing switch deasserts after edge k+1 → incoming switch asserts after edge k+1+dt_eff.
- Invariant: top and bottom of the same leg are never simultaneously 1, in any cycle, under any stimulus.
- en=0: on the next CE edge all legs go to OFF and Sp=Ss=0. When en returns to 1, legs restart from OFF through a full dead time.
- Fault: V1_r==2'b10 or V2_r==2'b10 sets fault=1 on the next CE edge.
  - All legs are forced to OFF and Sp=Ss=0.
  - The fault holds regardless of later inputs or en, and clears only on reset.
  - Fault has priority over en and over normal transitions.
- Simultaneous events:
  - V1 +1→-1 in one step: legs A and B commutate in parallel, each with its own dead time.
  - Fault and en=0 in the same cycle: fault wins.
- CE=0: everything frozen, including counters, outputs and fault; the freeze may stretch the dead time in wall-clock time but never shortens it.

Test Plan:
1. Reset with rst=0, then rst=1, en=1, CE=1, dt_cuentas=5, V1=V2=0 → after 1+1+5 edges Sp=Ss=4'b1010; fault=0 throughout; Sp=0 during reset.
2. Steady 4'b1010; V1 0→+1 at edge k → Sp[1] falls after edge k+1, Sp[0] rises after edge k+6, final Sp=4'b1001; Sp[0]&Sp[1] never 1.
3. V1 +1→-1 directly, dt=5 → Sp 4'b1001 → 4'b0000 for 5 cycles → 4'b0110; both legs' per-leg exclusivity checked every cycle.
4. dt_cuentas=0, V2 0→-1 → dead gap on Ss legs is exactly DT_MIN=2 cycles. Then V2 pulses +1 for 2 cycles during a dt=5 DT → top never asserts and bottom re-asserts.
5. V1=2'b10 for one cycle → fault=1 one edge after V1_r captures it; Sp=Ss=0 stays after V1 returns to 0 and en toggles; rst=0 clears fault=0.
6. CE held 0 for 10 cycles mid dead time (dt=5) → outputs and counter frozen; the gap resumes when CE returns and totals 5 CE cycles. en=0 → all gates 0 next edge; en=1 → restart via a 5-cycle dead time.

Source files
------------

// File: rtl/dab_gate_deadtime.sv
// Gate driver for a dual-active-bridge converter: decodes three-level bridge commands into eight gate signals.
// It inserts a per-leg dead time on each commutation and shuts down with a sticky fault on illegal command codes.
module dab_gate_deadtime #(
    parameter int DT_WIDTH = 8,
    parameter int DT_MIN   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                CE,
    input  logic                en,
    input  logic [DT_WIDTH-1:0] dt_cuentas,
    input  logic signed [1:0]   V1,
    input  logic signed [1:0]   V2,
    output logic [3:0]          Sp,
    output logic [3:0]          Ss,
    output logic                fault
);

    typedef enum logic [2:0] {
        OFF,
        LOW_ON,
        DT_TO_HIGH,
        HIGH_ON,
        DT_TO_LOW
    } leg_state_e;

    localparam logic [DT_WIDTH-1:0] DT_MIN_C = DT_WIDTH'(DT_MIN);
    localparam logic [DT_WIDTH-1:0] CNT_ONE  = DT_WIDTH'(1);
    localparam logic [1:0]          V_POS    = 2'b01;
    localparam logic [1:0]          V_NEG    = 2'b11;
    localparam logic [1:0]          V_BAD    = 2'b10;

    logic [1:0]          v1_q, v2_q;
    logic                fault_q, fault_d;
    leg_state_e          state_q [4];
    leg_state_e          state_d [4];
    logic [DT_WIDTH-1:0] cnt_q   [4];
    logic [DT_WIDTH-1:0] cnt_d   [4];
    logic [3:0]          sp_q, sp_d, ss_q, ss_d;

    logic [DT_WIDTH-1:0] dt_eff;
    logic [3:0]          want_high;
    logic                force_off;
    logic [3:0]          top, bot;

    // Legs 0/1 are primary A/B, legs 2/3 secondary A/B; leg A is high on +1, leg B on -1.
    always_comb begin
        dt_eff    = (dt_cuentas < DT_MIN_C) ? DT_MIN_C : dt_cuentas;
        want_high = {v2_q == V_NEG, v2_q == V_POS, v1_q == V_NEG, v1_q == V_POS};
        fault_d   = fault_q | (v1_q == V_BAD) | (v2_q == V_BAD);
        force_off = fault_d | ~en;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            // NOTE: defaults first so every path assigns every output and no latch is inferred.
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (force_off) begin
                state_d[i] = OFF;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    OFF: begin
                        state_d[i] = want_high[i] ? DT_TO_HIGH : DT_TO_LOW;
                        cnt_d[i]   = dt_eff;
                    end
                    LOW_ON: begin
                        if (want_high[i]) begin
                            state_d[i] = DT_TO_HIGH;
                            cnt_d[i]   = dt_eff;
                        end
                    end
                    DT_TO_HIGH: begin
                        // An aborted commutation falls straight back to the side that was on.
                        if (!want_high[i]) begin
                            state_d[i] = LOW_ON;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] <= CNT_ONE) begin
                            state_d[i] = HIGH_ON;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    HIGH_ON: begin
                        if (!want_high[i]) begin
                            state_d[i] = DT_TO_LOW;
                            cnt_d[i]   = dt_eff;
                        end
                    end
                    DT_TO_LOW: begin
                        if (want_high[i]) begin
                            state_d[i] = HIGH_ON;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] <= CNT_ONE) begin
                            state_d[i] = LOW_ON;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[i] = OFF;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Gates are decoded from the next state so they change on the same edge as the leg.
    always_comb begin
        top = '0;
        bot = '0;
        for (int i = 0; i < 4; i++) begin
            top[i] = (state_d[i] == HIGH_ON);
            bot[i] = (state_d[i] == LOW_ON);
        end
        sp_d = {bot[1], top[1], bot[0], top[0]};
        ss_d = {bot[3], top[3], bot[2], top[2]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q    <= '0;
            v2_q    <= '0;
            fault_q <= 1'b0;
            sp_q    <= '0;
            ss_q    <= '0;
            // NOTE: the per-leg arrays are tiny control state, not storage, so they are reset like any flop.
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= OFF;
                cnt_q[i]   <= '0;
            end
        end else if (CE) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            v1_q    <= V1;
            v2_q    <= V2;
            fault_q <= fault_d;
            sp_q    <= sp_d;
            ss_q    <= ss_d;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign Sp    = sp_q;
    assign Ss    = ss_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_dab_gate_deadtime.sv
// Scoreboard bench for dab_gate_deadtime: a per-leg "who conducts / how long until" model predicts every cycle.
// Stimulus pushes predictions into a queue; a negedge monitor pops and compares them with the DUT outputs.
module tb_dab_gate_deadtime;

    localparam int DT_MIN  = 2;
    localparam int C_NONE  = 0;
    localparam int C_LOW   = 1;
    localparam int C_HIGH  = 2;

    logic              clk = 1'b0;
    logic              rst, CE, en;
    logic [7:0]        dt_cuentas;
    logic signed [1:0] V1, V2;
    logic [3:0]        Sp, Ss;
    logic              fault;

    dab_gate_deadtime #(.DT_WIDTH(8), .DT_MIN(DT_MIN)) dut (
        .clk(clk), .rst(rst), .CE(CE), .en(en), .dt_cuentas(dt_cuentas),
        .V1(V1), .V2(V2), .Sp(Sp), .Ss(Ss), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [8:0] exp_q[$];

    // Reference model state: which switch of each leg conducts, and the pending dead gap.
    int   on_m  [4];
    int   gap_m [4];
    int   to_m  [4];
    int   vr_m  [2];
    bit   fault_m;

    // Current stimulus settings, applied every tick.
    logic       r_s, c_s, e_s;
    logic [7:0] dt_s;
    logic [1:0] v1_s, v2_s;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endtask

    function automatic int want(input int leg);
        int code;
        code = vr_m[leg / 2];
        if (leg % 2 == 0) return (code == 1) ? C_HIGH : C_LOW;
        return (code == 3) ? C_HIGH : C_LOW;
    endfunction

    task automatic model_edge(input logic r, c, e, input logic [7:0] dt, input logic [1:0] a, b);
        int dte, t;
        if (!r) begin
            fault_m = 1'b0;
            vr_m[0] = 0;
            vr_m[1] = 0;
            for (int l = 0; l < 4; l++) begin
                on_m[l] = C_NONE; gap_m[l] = 0; to_m[l] = C_NONE;
            end
        end else if (c) begin
            if (vr_m[0] == 2 || vr_m[1] == 2) fault_m = 1'b1;
            dte = (int'(dt) < DT_MIN) ? DT_MIN : int'(dt);
            for (int l = 0; l < 4; l++) begin
                if (fault_m || !e) begin
                    on_m[l] = C_NONE; gap_m[l] = 0;
                end else begin
                    t = want(l);
                    if (gap_m[l] == 0) begin
                        if (on_m[l] != t) begin
                            on_m[l] = C_NONE; gap_m[l] = dte; to_m[l] = t;
                        end
                    end else if (t != to_m[l]) begin
                        on_m[l] = t; gap_m[l] = 0;
                    end else if (gap_m[l] == 1) begin
                        on_m[l] = to_m[l]; gap_m[l] = 0;
                    end else begin
                        gap_m[l] = gap_m[l] - 1;
                    end
                end
            end
            vr_m[0] = int'(a);
            vr_m[1] = int'(b);
        end
    endtask

    function automatic logic [8:0] model_out();
        logic [7:0] g;
        for (int l = 0; l < 4; l++) begin
            g[2*l]   = (on_m[l] == C_HIGH);
            g[2*l+1] = (on_m[l] == C_LOW);
        end
        return {g[3:0], g[7:4], fault_m};
    endfunction

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst = r_s; CE = c_s; en = e_s; dt_cuentas = dt_s; V1 = v1_s; V2 = v2_s;
            @(posedge clk);
            model_edge(r_s, c_s, e_s, dt_s, v1_s, v2_s);
            exp_q.push_back(model_out());
        end
    endtask

    task automatic check_now(input string name, input logic [8:0] exp);
        #1;
        check(name, {Sp, Ss, fault}, exp);
    endtask

    // Monitor: every cycle the DUT presents a gate pattern; compare against the oldest prediction.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gates", {Sp, Ss, fault}, e);
                check("shoot_through", {5'd0, Sp[0] & Sp[1], Sp[2] & Sp[3], Ss[0] & Ss[1], Ss[2] & Ss[3]}, 9'd0);
            end
        end
    end

    initial begin
        r_s = 0; c_s = 1; e_s = 0; dt_s = 8'd5; v1_s = 2'b00; v2_s = 2'b00;
        rst = 0; CE = 1; en = 0; dt_cuentas = 8'd5; V1 = 2'b00; V2 = 2'b00;
        for (int l = 0; l < 4; l++) begin
            on_m[l] = C_NONE; gap_m[l] = 0; to_m[l] = C_NONE;
        end
        vr_m[0] = 0; vr_m[1] = 0; fault_m = 0;

        // Reset, then power up into both-legs-low.
        tick(3);
        check_now("reset_state", 9'd0);
        r_s = 1; e_s = 1;
        tick(4);
        check_now("startup_in_deadtime", 9'd0);
        tick(4);
        check_now("startup_low", {4'b1010, 4'b1010, 1'b0});

        // V1 0 -> +1: bottom A drops after k+1, top A rises after k+6.
        v1_s = 2'b01;
        tick(2);
        check_now("p_pos_gap_start", {4'b1000, 4'b1010, 1'b0});
        tick(4);
        check_now("p_pos_gap_end", {4'b1000, 4'b1010, 1'b0});
        tick(1);
        check_now("p_pos_on", {4'b1001, 4'b1010, 1'b0});

        // V1 +1 -> -1 directly: both legs commutate together.
        v1_s = 2'b11;
        tick(2);
        check_now("p_rev_gap", {4'b0000, 4'b1010, 1'b0});
        tick(4);
        check_now("p_rev_gap_end", {4'b0000, 4'b1010, 1'b0});
        tick(1);
        check_now("p_rev_on", {4'b0110, 4'b1010, 1'b0});

        // Clamped dead time of DT_MIN cycles on the secondary.
        dt_s = 8'd0; v2_s = 2'b11;
        tick(3);
        check_now("s_min_gap", {4'b0110, 4'b0010, 1'b0});
        tick(1);
        check_now("s_min_on", {4'b0110, 4'b0110, 1'b0});

        // Short +1 pulse aborts mid dead time; tops never pulse.
        dt_s = 8'd5; v2_s = 2'b01;
        tick(2);
        v2_s = 2'b11;
        tick(2);
        check_now("s_abort_restore", {4'b0110, 4'b0110, 1'b0});
        tick(6);

        // Illegal code latches a fault that survives input and enable changes.
        v1_s = 2'b10;
        tick(1);
        v1_s = 2'b00;
        tick(1);
        check_now("fault_set", {4'b0000, 4'b0000, 1'b1});
        e_s = 0; tick(2); e_s = 1; tick(8);
        check_now("fault_sticky", {4'b0000, 4'b0000, 1'b1});
        r_s = 0;
        tick(1);
        check_now("fault_cleared", 9'd0);

        // CE freeze in the middle of a dead time only stretches it.
        r_s = 1; v2_s = 2'b00;
        tick(8);
        v1_s = 2'b01;
        tick(3);
        c_s = 0;
        tick(10);
        check_now("ce_frozen", {4'b1000, 4'b1010, 1'b0});
        c_s = 1;
        tick(3);
        check_now("ce_resume_gap", {4'b1000, 4'b1010, 1'b0});
        tick(1);
        check_now("ce_resume_on", {4'b1001, 4'b1010, 1'b0});

        // Enable drop and full dead-time restart.
        e_s = 0;
        tick(1);
        check_now("en_off", 9'd0);
        e_s = 1;
        tick(4);
        check_now("en_restart_gap", 9'd0);
        tick(2);
        check_now("en_restart_on", {4'b1001, 4'b1010, 1'b0});

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r_s = ($urandom_range(0, 399) != 0) && !(fault_m && $urandom_range(0, 15) == 0);
            c_s = ($urandom_range(0, 9) < 8);
            e_s = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 19) == 0) dt_s = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 199) == 0) v1_s = 2'b10;
                else begin
                    case ($urandom_range(0, 2))
                        0: v1_s = 2'b00;
                        1: v1_s = 2'b01;
                        default: v1_s = 2'b11;
                    endcase
                end
            end else if (v1_s == 2'b10) v1_s = 2'b00;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: v2_s = 2'b00;
                    1: v2_s = 2'b01;
                    default: v2_s = 2'b11;
                endcase
            end
            tick(1);
        end

        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", 9'(exp_q.size()), 9'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
